// File: rtl/core_pkg.sv
// Core-wide parameters and shared types for the front-end instruction queue.
package core_pkg;
   localparam int unsigned XLEN        = 32;
   localparam int unsigned FETCH_WIDTH = 2;
   localparam int unsigned IQ_DEPTH    = 8;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } iq_entry_t;

   function automatic logic [1:0] pop2(input logic [1:0] v);
      return 2'(v[0]) + 2'(v[1]);
   endfunction
endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode-side bundle of the instruction queue; slave = queue, master = its environment.
interface inst_queue_if #(
   parameter int unsigned XLEN        = core_pkg::XLEN,
   parameter int unsigned FETCH_WIDTH = core_pkg::FETCH_WIDTH,
   parameter int unsigned IQ_DEPTH    = core_pkg::IQ_DEPTH
);
   localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

   logic                             flush_pipeline;
   logic                             redirect_en;
   logic [FETCH_WIDTH-1:0]           in_valid;
   logic [FETCH_WIDTH-1:0][XLEN-1:0] in_pc;
   logic [FETCH_WIDTH-1:0][XLEN-1:0] in_instr;
   logic                             iq_stall;
   logic [FETCH_WIDTH-1:0]           out_valid;
   logic [FETCH_WIDTH-1:0][XLEN-1:0] out_pc;
   logic [FETCH_WIDTH-1:0][XLEN-1:0] out_instr;
   logic                             dec_ready;
   logic [CW-1:0]                    iq_count;

   modport slave (
      input  flush_pipeline, redirect_en, in_valid, in_pc, in_instr, dec_ready,
      output iq_stall, out_valid, out_pc, out_instr, iq_count
   );

   modport master (
      output flush_pipeline, redirect_en, in_valid, in_pc, in_instr, dec_ready,
      input  iq_stall, out_valid, out_pc, out_instr, iq_count
   );
endinterface

// File: rtl/iq_storage_2w2r.sv
// Unreset 2-write / 2-read register array of queue entries with asynchronous read.
module iq_storage_2w2r
   import core_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic      clk,
   input  logic      we0,
   input  logic [AW-1:0] waddr0,
   input  iq_entry_t wdata0,
   input  logic      we1,
   input  logic [AW-1:0] waddr1,
   input  iq_entry_t wdata1,
   input  logic [AW-1:0] raddr0,
   input  logic [AW-1:0] raddr1,
   output iq_entry_t rdata0,
   output iq_entry_t rdata1
);
   iq_entry_t mem_q [DEPTH];

   // Write addresses are always distinct when both ports fire (tail and tail+1).
   always_ff @(posedge clk) begin
      if (we0) mem_q[waddr0] <= wdata0;
      if (we1) mem_q[waddr1] <= wdata1;
   end

   assign rdata0 = mem_q[raddr0];
   assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/inst_queue.sv
// Two-wide circular instruction queue between fetch and decode, with flush/redirect discard.
module inst_queue #(
   parameter int unsigned XLEN        = core_pkg::XLEN,
   parameter int unsigned FETCH_WIDTH = core_pkg::FETCH_WIDTH,
   parameter int unsigned IQ_DEPTH    = core_pkg::IQ_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   inst_queue_if.slave   io
);
   import core_pkg::*;

   localparam int unsigned PW = $clog2(IQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    n_enq, n_deq, out_valid_c;
   logic          stall, kill, we0, we1;
   logic [PW-1:0] widx0, widx1;
   iq_entry_t     wdata0, wdata1, rdata0, rdata1;

   // Pointer/count next-state; stall comes from the registered count only.
   always_comb begin
      stall       = count_q > CW'(IQ_DEPTH - 2);
      out_valid_c = {count_q >= CW'(2), count_q != '0};
      kill        = io.flush_pipeline | io.redirect_en;
      n_enq       = (!stall && !kill) ? pop2(2'(io.in_valid)) : 2'd0;
      n_deq       = (io.dec_ready && !kill) ? pop2(out_valid_c) : 2'd0;
      we0         = n_enq != 2'd0;
      we1         = n_enq == 2'd2;
      widx0       = tail_q;
      widx1       = tail_q + PW'(1);
      // Compact valid lanes: a lone lane-1 instruction goes to the tail slot.
      wdata0      = io.in_valid[0] ? '{pc: io.in_pc[0], instr: io.in_instr[0]}
                                   : '{pc: io.in_pc[1], instr: io.in_instr[1]};
      wdata1      = '{pc: io.in_pc[1], instr: io.in_instr[1]};
      head_d      = head_q + PW'(n_deq);
      tail_d      = tail_q + PW'(n_enq);
      count_d     = count_q + CW'(n_enq) - CW'(n_deq);
      if (kill) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) assert (count_q <= CW'(IQ_DEPTH));
   end

   iq_storage_2w2r #(.DEPTH(IQ_DEPTH)) u_storage (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (widx0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (widx1),
      .wdata1 (wdata1),
      .raddr0 (head_q),
      .raddr1 (head_q + PW'(1)),
      .rdata0 (rdata0),
      .rdata1 (rdata1)
   );

   assign io.iq_stall     = stall;
   assign io.iq_count     = count_q;
   assign io.out_valid    = FETCH_WIDTH'(out_valid_c);
   assign io.out_pc[0]    = XLEN'(rdata0.pc);
   assign io.out_pc[1]    = XLEN'(rdata1.pc);
   assign io.out_instr[0] = XLEN'(rdata0.instr);
   assign io.out_instr[1] = XLEN'(rdata1.instr);
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: handshake, stall boundary, wrap, flush/redirect, reset.
module tb_inst_queue;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   inst_queue_if q_if ();

   inst_queue u_dut (
      .clk   (clk),
      .reset (reset),
      .io    (q_if.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
      q_if.in_valid    = v;
      q_if.in_pc[0]    = pc0;
      q_if.in_pc[1]    = pc1;
      q_if.in_instr[0] = ins_of(pc0);
      q_if.in_instr[1] = ins_of(pc1);
   endtask

   logic [31:0] exp_q [$];
   logic [31:0] pc_next;
   int          sent, popped, ndeq, sz;
   logic        enq;

   initial begin
      reset = 1'b1;
      q_if.flush_pipeline = 1'b0;
      q_if.redirect_en    = 1'b0;
      q_if.dec_ready      = 1'b0;
      drive(2'b00, 32'h0, 32'h0);
      tick(); tick();
      reset = 1'b0;
      chk("rst_count", 32'(q_if.iq_count), 32'd0);
      chk("rst_valid", 32'(q_if.out_valid), 32'd0);
      chk("rst_stall", 32'(q_if.iq_stall), 32'd0);

      // First pair becomes visible one edge after it is written
      drive(2'b11, 32'h0, 32'h4);
      tick();
      chk("pair_count", 32'(q_if.iq_count), 32'd2);
      chk("pair_valid", 32'(q_if.out_valid), 32'd3);
      chk("pair_pc0", q_if.out_pc[0], 32'h0);
      chk("pair_pc1", q_if.out_pc[1], 32'h4);
      chk("pair_in1", q_if.out_instr[1], ins_of(32'h4));

      // Fill: stall only once count exceeds depth-2
      drive(2'b11, 32'h8, 32'hC);   tick();
      drive(2'b11, 32'h10, 32'h14); tick();
      chk("cnt6_stall", 32'(q_if.iq_stall), 32'd0);
      drive(2'b11, 32'h18, 32'h1C); tick();
      chk("cnt8_count", 32'(q_if.iq_count), 32'd8);
      chk("cnt8_stall", 32'(q_if.iq_stall), 32'd1);
      drive(2'b11, 32'h20, 32'h24); tick();
      chk("held_count", 32'(q_if.iq_count), 32'd8);
      q_if.dec_ready = 1'b1; tick();
      chk("pop_only_count", 32'(q_if.iq_count), 32'd6);
      chk("pop_only_pc0", q_if.out_pc[0], 32'h8);
      q_if.dec_ready = 1'b0; tick();
      chk("held_enq_count", 32'(q_if.iq_count), 32'd8);
      drive(2'b00, 32'h0, 32'h0);
      q_if.dec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc0", q_if.out_pc[0], 32'h8 + 32'(i) * 32'h8);
         chk("drain_pc1", q_if.out_pc[1], 32'hC + 32'(i) * 32'h8);
         tick();
      end
      chk("drain_count", 32'(q_if.iq_count), 32'd0);
      chk("drain_valid", 32'(q_if.out_valid), 32'd0);
      q_if.dec_ready = 1'b0;

      // Count 7 with stall: only dequeue, then the held pair goes in
      drive(2'b11, 32'h200, 32'h204); tick();
      drive(2'b11, 32'h208, 32'h20C); tick();
      drive(2'b11, 32'h210, 32'h214); tick();
      drive(2'b01, 32'h218, 32'h0);   tick();
      chk("c7_count", 32'(q_if.iq_count), 32'd7);
      chk("c7_stall", 32'(q_if.iq_stall), 32'd1);
      drive(2'b11, 32'h220, 32'h224);
      q_if.dec_ready = 1'b1; tick();
      chk("c7_deq_count", 32'(q_if.iq_count), 32'd5);
      chk("c7_deq_pc0", q_if.out_pc[0], 32'h208);
      chk("c7_deq_stall", 32'(q_if.iq_stall), 32'd0);
      q_if.dec_ready = 1'b0; tick();
      chk("c7_enq_count", 32'(q_if.iq_count), 32'd7);

      // Redirect at count 5 discards same-cycle enqueue and dequeue
      drive(2'b00, 32'h0, 32'h0);
      q_if.dec_ready = 1'b1; tick();
      chk("c5_count", 32'(q_if.iq_count), 32'd5);
      drive(2'b11, 32'h2F0, 32'h2F4);
      q_if.redirect_en = 1'b1; tick();
      q_if.redirect_en = 1'b0;
      chk("redir_count", 32'(q_if.iq_count), 32'd0);
      chk("redir_valid", 32'(q_if.out_valid), 32'd0);
      chk("redir_stall", 32'(q_if.iq_stall), 32'd0);
      q_if.dec_ready = 1'b0;
      drive(2'b11, 32'h300, 32'h304); tick();
      chk("post_redir_pc0", q_if.out_pc[0], 32'h300);
      chk("post_redir_pc1", q_if.out_pc[1], 32'h304);
      drive(2'b11, 32'h3F0, 32'h3F4);
      q_if.flush_pipeline = 1'b1;
      q_if.redirect_en    = 1'b1; tick();
      q_if.flush_pipeline = 1'b0;
      q_if.redirect_en    = 1'b0;
      chk("flush_count", 32'(q_if.iq_count), 32'd0);

      // Lane-1-only enqueue compacts to the tail slot
      drive(2'b10, 32'hDEAD, 32'h104); tick();
      chk("l1_count", 32'(q_if.iq_count), 32'd1);
      chk("l1_valid", 32'(q_if.out_valid), 32'd1);
      chk("l1_pc0", q_if.out_pc[0], 32'h104);
      chk("l1_in0", q_if.out_instr[0], ins_of(32'h104));
      drive(2'b01, 32'h108, 32'hBEEF); tick();
      chk("l0_pc1", q_if.out_pc[1], 32'h108);

      // Reset mid-operation beats flush, enqueue and dequeue
      drive(2'b11, 32'h400, 32'h404);
      q_if.dec_ready = 1'b1;
      q_if.flush_pipeline = 1'b1;
      reset = 1'b1; tick();
      reset = 1'b0;
      q_if.flush_pipeline = 1'b0;
      q_if.dec_ready = 1'b0;
      drive(2'b00, 32'h0, 32'h0);
      chk("midrst_count", 32'(q_if.iq_count), 32'd0);
      chk("midrst_valid", 32'(q_if.out_valid), 32'd0);

      // Streaming 20 pairs with alternating dec_ready against a queue model
      pc_next = 32'h1000;
      sent    = 0;
      popped  = 0;
      for (int cyc = 0; cyc < 400 && (sent < 20 || exp_q.size() > 0); cyc++) begin
         q_if.dec_ready = cyc[0];
         sz = exp_q.size();
         chk("st_count", 32'(q_if.iq_count), 32'(sz));
         chk("st_stall", 32'(q_if.iq_stall), (sz > 6) ? 32'd1 : 32'd0);
         chk("st_valid", 32'(q_if.out_valid), (sz >= 2) ? 32'd3 : ((sz == 1) ? 32'd1 : 32'd0));
         if (sz >= 1) chk("st_pc0", q_if.out_pc[0], exp_q[0]);
         if (sz >= 2) chk("st_pc1", q_if.out_pc[1], exp_q[1]);
         enq = (sz <= 6) && (sent < 20);
         if (enq) drive(2'b11, pc_next, pc_next + 32'h4);
         else     drive(2'b00, 32'h0, 32'h0);
         ndeq = q_if.dec_ready ? ((sz >= 2) ? 2 : sz) : 0;
         for (int k = 0; k < ndeq; k++) void'(exp_q.pop_front());
         popped += ndeq;
         if (enq) begin
            exp_q.push_back(pc_next);
            exp_q.push_back(pc_next + 32'h4);
            sent++;
            pc_next += 32'h8;
         end
         tick();
      end
      drive(2'b00, 32'h0, 32'h0);
      q_if.dec_ready = 1'b0;
      chk("st_popped", 32'(popped), 32'd40);
      chk("st_end_count", 32'(q_if.iq_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
